// File: rtl/ram_load_injector_pkg.sv
// Shared types for the RAM preload engine: FSM state encoding and pattern selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_load_injector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Pattern select codes; any other value produces all-zero data.
  localparam int SEL_ADDR  = 0;
  localparam int SEL_IDX   = 1;
  localparam int SEL_WALK1 = 2;
  localparam int SEL_ALT   = 3;
  localparam int SEL_ONES  = 4;

endpackage

// File: rtl/ram_load_pattern_gen.sv
// Purpose: combinational write-data generator for the RAM preload engine.
// Latency: zero (pure combinational). Backpressure: none.
// Ports: sel_i pattern select, addr_i current address, idx_i write index,
//        wdata_o generated data (addr/idx zero-extended or truncated to DW).
module ram_load_pattern_gen
  import ram_load_injector_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int SW = 8
) (
  input  logic [SW-1:0] sel_i,
  input  logic [AW-1:0] addr_i,
  input  logic [AW-1:0] idx_i,
  output logic [DW-1:0] wdata_o
);

  always_comb begin
    wdata_o = '0;
    if (sel_i == SW'(SEL_ADDR)) begin
      wdata_o = DW'(addr_i);
    end else if (sel_i == SW'(SEL_IDX)) begin
      wdata_o = DW'(idx_i);
    end else if (sel_i == SW'(SEL_WALK1)) begin
      wdata_o = DW'(1) << (int'(idx_i) % DW);
    end else if (sel_i == SW'(SEL_ALT)) begin
      // Even index gives 1010.. (odd bits set), odd index gives 0101..
      for (int b = 0; b < DW; b++) begin
        wdata_o[b] = (b % 2 == 1) ^ idx_i[0];
      end
    end else if (sel_i == SW'(SEL_ONES)) begin
      wdata_o = '1;
    end
  end

endmodule

// File: rtl/ram_load_injector.sv
// Purpose: on a rising edge of i_start, write a pattern to RAM addresses start..stop
//          (inclusive, wrapping mod 2^AW), one write per clock, then pulse o_done.
// Latency: first write visible one cycle after the start edge is sampled; no backpressure.
// Ports: clk, rst_n (sync, active-high); i_ram_start_addr/i_ram_stop_addr range,
//        i_sel pattern, i_start request; o_me/o_we/o_addr/o_wdata RAM port, o_done pulse;
//        i_rdata unused.
module ram_load_injector
  import ram_load_injector_pkg::*;
#(
  parameter int G_RAM_ADDR_WIDTH = 8,
  parameter int G_RAM_DATA_WIDTH = 8,
  parameter int G_SEL_WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_ram_start_addr,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_ram_stop_addr,
  input  logic [G_SEL_WIDTH-1:0]      i_sel,
  input  logic                        i_start,
  output logic                        o_me,
  output logic                        o_we,
  output logic [G_RAM_ADDR_WIDTH-1:0] o_addr,
  output logic [G_RAM_DATA_WIDTH-1:0] o_wdata,
  input  logic [G_RAM_DATA_WIDTH-1:0] i_rdata,
  output logic                        o_done
);

  localparam int AW = G_RAM_ADDR_WIDTH;
  localparam int DW = G_RAM_DATA_WIDTH;
  localparam int SW = G_SEL_WIDTH;

  state_e          state_q, state_d;
  logic            start_prev_q;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   stop_q, stop_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            done_q, done_d;
  logic [DW-1:0]   pat_wdata;

  // Read data plays no part in a preload.
  logic unused_rdata;
  assign unused_rdata = ^i_rdata;

  ram_load_pattern_gen #(
    .AW(AW),
    .DW(DW),
    .SW(SW)
  ) u_pattern_gen (
    .sel_i  (sel_q),
    .addr_i (cnt_q),
    .idx_i  (idx_q),
    .wdata_o(pat_wdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    sel_d   = sel_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    // Address/data hold their last value while no write is in progress.
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        // Range and pattern are latched here so later input changes cannot disturb a load.
        if (i_start && !start_prev_q) begin
          cnt_d   = i_ram_start_addr;
          stop_d  = i_ram_stop_addr;
          sel_d   = i_sel;
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_d    = 1'b1;
        addr_d  = cnt_q;
        wdata_d = pat_wdata;
        // Equality test (not <=) lets a stop below start wrap through the top address.
        if (cnt_q == stop_q) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      stop_q       <= '0;
      sel_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      // Sampled in every state, so a level held through a load never retriggers.
      start_prev_q <= i_start;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stop_q       <= stop_d;
      sel_q        <= sel_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
    end
  end

  assign o_me    = wr_q;
  assign o_we    = wr_q;
  assign o_addr  = addr_q;
  assign o_wdata = wdata_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_ram_load_injector.sv
// Bench for ram_load_injector: directed loads with hand-computed expected writes,
// checked by a scoreboard monitor on the falling clock edge.
module tb_ram_load_injector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_ram_start_addr;
  logic [7:0] i_ram_stop_addr;
  logic [7:0] i_sel;
  logic       i_start;
  logic       o_me;
  logic       o_we;
  logic [7:0] o_addr;
  logic [7:0] o_wdata;
  logic [7:0] i_rdata;
  logic       o_done;

  always #5 clk = ~clk;

  ram_load_injector #(
    .G_RAM_ADDR_WIDTH(8),
    .G_RAM_DATA_WIDTH(8),
    .G_SEL_WIDTH     (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_ram_start_addr(i_ram_start_addr),
    .i_ram_stop_addr (i_ram_stop_addr),
    .i_sel           (i_sel),
    .i_start         (i_start),
    .o_me            (o_me),
    .o_we            (o_we),
    .o_addr          (o_addr),
    .o_wdata         (o_wdata),
    .i_rdata         (i_rdata),
    .o_done          (o_done)
  );

  typedef struct {
    int         cyc;
    logic       is_done;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] walk_tbl[4] = '{8'h01, 8'h02, 8'h04, 8'h08};
  logic [7:0] wrap_addr[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic [7:0] wrap_data[4] = '{8'h00, 8'h01, 8'h02, 8'h03};
  logic [7:0] alt_tbl[6]  = '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle with any write/done activity must match the queue head.
  always @(negedge clk) begin
    if (o_me === 1'b1 || o_we === 1'b1 || o_done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d me=%b we=%b done=%b addr=%h data=%h required=none",
                 cyc, o_me, o_we, o_done, o_addr, o_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc != mon_e.cyc || o_done !== mon_e.is_done ||
            o_me !== ~mon_e.is_done || o_we !== ~mon_e.is_done ||
            (!mon_e.is_done && (o_addr !== mon_e.addr || o_wdata !== mon_e.data))) begin
          errors++;
          $display("FAIL %s actual cyc=%0d me=%b we=%b done=%b addr=%h data=%h required cyc=%0d done=%b addr=%h data=%h",
                   mon_e.is_done ? "done_pulse" : "write", cyc, o_me, o_we, o_done, o_addr, o_wdata,
                   mon_e.cyc, mon_e.is_done, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic push_w(input int c, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.is_done = 1'b0; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_d(input int c);
    exp_t e;
    e.cyc = c; e.is_done = 1'b1; e.addr = 8'h00; e.data = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One-cycle start pulse; base is the cycle in which i_start rises (sampled at base+1).
  task automatic go(input logic [7:0] sa, input logic [7:0] so, input logic [7:0] sl,
                    output int base);
    @(posedge clk); #1;
    i_ram_start_addr = sa;
    i_ram_stop_addr  = so;
    i_sel            = sl;
    i_start          = 1'b1;
    base             = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b1;
    i_start = 1'b0;
    i_ram_start_addr = 8'h00;
    i_ram_stop_addr = 8'h00;
    i_sel = 8'h00;
    i_rdata = 8'h5A;

    // Reset: start pulses while held in reset must not launch a load.
    @(posedge clk); #1; i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    @(posedge clk); #1;
    chk("rst_me", {31'd0, o_me}, 32'd0);
    chk("rst_we", {31'd0, o_we}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_addr", {24'd0, o_addr}, 32'd0);
    chk("rst_wdata", {24'd0, o_wdata}, 32'd0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle_me", {31'd0, o_me}, 32'd0);

    // 0..7, address pattern.
    go(8'h00, 8'h07, 8'd0, base);
    for (int i = 0; i < 8; i++) push_w(base + 2 + i, 8'(i), 8'(i));
    push_d(base + 10);
    drain();

    // 0x10..0x13, walking one.
    go(8'h10, 8'h13, 8'd2, base);
    for (int i = 0; i < 4; i++) push_w(base + 2 + i, 8'h10 + 8'(i), walk_tbl[i]);
    push_d(base + 6);
    drain();

    // Wrap 0xFE..0x01, index pattern.
    go(8'hFE, 8'h01, 8'd1, base);
    for (int i = 0; i < 4; i++) push_w(base + 2 + i, wrap_addr[i], wrap_data[i]);
    push_d(base + 6);
    drain();

    // Single write, all ones.
    go(8'h20, 8'h20, 8'd4, base);
    push_w(base + 2, 8'h20, 8'hFF);
    push_d(base + 3);
    drain();

    // Unknown select gives zeros.
    go(8'h40, 8'h41, 8'd9, base);
    push_w(base + 2, 8'h40, 8'h00);
    push_w(base + 3, 8'h41, 8'h00);
    push_d(base + 4);
    drain();

    // 0x30..0x35 alternating; start re-pulsed and inputs changed mid-load, then held high past done.
    @(posedge clk); #1;
    i_ram_start_addr = 8'h30;
    i_ram_stop_addr  = 8'h35;
    i_sel            = 8'd3;
    i_start          = 1'b1;
    base             = cyc;
    for (int i = 0; i < 6; i++) push_w(base + 2 + i, 8'h30 + 8'(i), alt_tbl[i]);
    push_d(base + 8);
    @(posedge clk); #1;
    @(posedge clk); #1; i_start = 1'b0;
    @(posedge clk); #1;
    i_start          = 1'b1;
    i_ram_start_addr = 8'h00;
    i_ram_stop_addr  = 8'hFF;
    i_sel            = 8'd0;
    repeat (7) @(posedge clk);
    #1; i_start = 1'b0;
    drain();

    // Reset during the third write of 0..9: load aborts with no done pulse.
    go(8'h00, 8'h09, 8'd0, base);
    for (int i = 0; i < 3; i++) push_w(base + 2 + i, 8'(i), 8'(i));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; rst_n = 1'b0;
    chk("abort_me", {31'd0, o_me}, 32'd0);
    chk("abort_we", {31'd0, o_we}, 32'd0);
    chk("abort_done", {31'd0, o_done}, 32'd0);
    drain();

    // Fresh load after the abort.
    go(8'h50, 8'h52, 8'd0, base);
    for (int i = 0; i < 3; i++) push_w(base + 2 + i, 8'h50 + 8'(i), 8'h50 + 8'(i));
    push_d(base + 5);
    drain();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
